// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM request arbiter.
//   arb_mode_t  : arbitration policy (fixed priority or round-robin)
//   arb_state_t : arbiter FSM states
//   id_width()  : width of a master tag (0 = none, i+1 = master i)
package sdram_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic int id_width(input int num_masters);
        return $clog2(num_masters + 1);
    endfunction

endpackage

// File: rtl/arb_picker.sv
// Combinational winner selection.
//   i_request : per-master request vector
//   i_start   : index where the rotating search begins (0 for fixed priority)
//   i_starved : per-master starvation flags
//   o_winner  : chosen master index
//   o_valid   : at least one master is requesting
// A requesting starved master always wins (lowest index among them);
// otherwise the first requester at or after i_start, wrapping around.
module arb_picker #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_request,
    input  logic [IDX_W-1:0]       i_start,
    input  logic [NUM_MASTERS-1:0] i_starved,
    output logic [IDX_W-1:0]       o_winner,
    output logic                   o_valid
);

    logic [NUM_MASTERS-1:0] w_starved_req;
    int                     w_j;

    assign w_starved_req = i_request & i_starved;

    // Both searches run from the far end backwards so the last hit is the
    // nearest candidate.
    always_comb begin
        o_winner = '0;
        o_valid  = |i_request;
        w_j      = 0;
        if (|w_starved_req) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (w_starved_req[IDX_W'(i)]) o_winner = IDX_W'(i);
            end
        end else begin
            for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
                w_j = int'(i_start) + k;
                if (w_j >= NUM_MASTERS) w_j = w_j - NUM_MASTERS;
                if (i_request[IDX_W'(w_j)]) o_winner = IDX_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter_n.sv
// N-master arbiter in front of a single SDRAM controller port.
//   clock, reset_n      : single clock, synchronous active-low reset
//   bus_*  (inputs)     : packed per-master request, address, write, burst,
//                         byte enables and write data
//   bus_ack             : granted master's request accepted (same cycle as sdram_ack)
//   bus_rdata/rdvalid/complete : read return, routed by sdram_rdvalid tag
//   sdram_req           : tag of granted master (0 = idle)
//   sdram_addr..wdata   : granted master's request fields
//   sdram_ack, sdram_rdata, sdram_rdvalid, sdram_complete : controller side
// FSM: IDLE picks a winner and registers it; GRANT holds it until sdram_ack,
// then returns to IDLE, giving one dead cycle between grants.
module sdram_arbiter_n
    import sdram_arb_pkg::*;
#(
    parameter int        NUM_MASTERS  = 4,
    parameter int        ADDR_WIDTH   = 26,
    parameter int        DATA_WIDTH   = 32,
    parameter arb_mode_t ARB_MODE     = ARB_FIXED,
    parameter int        STARVE_LIMIT = 64,
    localparam int       ID_W         = id_width(NUM_MASTERS),
    localparam int       BE_W         = DATA_WIDTH / 8
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [NUM_MASTERS-1:0]            bus_request,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] bus_addr,
    input  logic [NUM_MASTERS-1:0]            bus_write,
    input  logic [NUM_MASTERS-1:0]            bus_burst,
    input  logic [NUM_MASTERS*BE_W-1:0]       bus_byte_enable,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] bus_wdata,
    output logic [NUM_MASTERS-1:0]            bus_ack,
    output logic [DATA_WIDTH-1:0]             bus_rdata,
    output logic [NUM_MASTERS-1:0]            bus_rdvalid,
    output logic [NUM_MASTERS-1:0]            bus_complete,
    output logic [ID_W-1:0]                   sdram_req,
    output logic [ADDR_WIDTH-1:0]             sdram_addr,
    output logic                              sdram_write,
    output logic                              sdram_burst,
    output logic [BE_W-1:0]                   sdram_byte_enable,
    output logic [DATA_WIDTH-1:0]             sdram_wdata,
    input  logic                              sdram_ack,
    input  logic [DATA_WIDTH-1:0]             sdram_rdata,
    input  logic [ID_W-1:0]                   sdram_rdvalid,
    input  logic                              sdram_complete
);

    localparam int               IDX_W    = $clog2(NUM_MASTERS);
    localparam int               WAIT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);

    arb_state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]       r_grant, w_grant_nxt;
    logic [IDX_W-1:0]       r_last_grant;
    logic [IDX_W-1:0]       w_start, w_winner;
    logic                   w_win_valid;
    logic                   w_granted;
    logic [NUM_MASTERS-1:0] w_grant_ack;
    logic [NUM_MASTERS-1:0] w_starved;
    logic [NUM_MASTERS-1:0] w_rdvalid;

    logic [ADDR_WIDTH-1:0]  w_addr_arr  [NUM_MASTERS];
    logic [BE_W-1:0]        w_be_arr    [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  w_wdata_arr [NUM_MASTERS];

    // Round-robin search starts just past the last acknowledged master.
    assign w_start = (ARB_MODE == ARB_RR)
                     ? ((r_last_grant == LAST_RST) ? '0 : r_last_grant + IDX_W'(1))
                     : '0;

    arb_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .i_request (bus_request),
        .i_start   (w_start),
        .i_starved (w_starved),
        .o_winner  (w_winner),
        .o_valid   (w_win_valid)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_win_valid) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_nxt = w_winner;
                end
            end
            ST_GRANT: begin
                if (sdram_ack) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_last_grant <= LAST_RST;
        end else if (w_granted && sdram_ack) begin
            r_last_grant <= r_grant;
        end
    end

    assign w_granted   = (r_state == ST_GRANT);
    assign w_grant_ack = (w_granted && sdram_ack) ? (NUM_MASTERS'(1) << r_grant) : '0;

    assign bus_ack           = w_grant_ack;
    assign sdram_req         = w_granted ? (ID_W'(r_grant) + ID_W'(1)) : '0;
    assign sdram_addr        = w_addr_arr[r_grant];
    assign sdram_write       = bus_write[r_grant];
    assign sdram_burst       = bus_burst[r_grant];
    assign sdram_byte_enable = w_be_arr[r_grant];
    assign sdram_wdata       = w_wdata_arr[r_grant];

    // Read return depends only on the controller's tag, never on the grant.
    assign bus_rdata    = sdram_rdata;
    assign bus_rdvalid  = w_rdvalid;
    assign bus_complete = w_rdvalid & {NUM_MASTERS{sdram_complete}};

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
        logic [WAIT_W-1:0] r_wait;

        assign w_addr_arr[gi]  = bus_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_be_arr[gi]    = bus_byte_enable[gi*BE_W +: BE_W];
        assign w_wdata_arr[gi] = bus_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign w_rdvalid[gi]   = (sdram_rdvalid == ID_W'(gi + 1));
        assign w_starved[gi]   = (ARB_MODE == ARB_FIXED) && (r_wait == WAIT_W'(STARVE_LIMIT));

        // Holds (does not count) while this master owns the grant.
        always_ff @(posedge clock) begin
            if (!reset_n || (ARB_MODE != ARB_FIXED) || !bus_request[gi] || w_grant_ack[gi]) begin
                r_wait <= '0;
            end else if (!(w_granted && (r_grant == IDX_W'(gi))) &&
                         (r_wait != WAIT_W'(STARVE_LIMIT))) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && w_granted && !sdram_ack) begin
            assert (bus_request[r_grant])
                else $error("sdram_arbiter_n: granted master dropped request before ack");
        end
    end

endmodule

// File: tb/tb_sdram_arbiter_n.sv
module tb_sdram_arbiter_n;
    import sdram_arb_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int BW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]    tag;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          write;
        logic [BW-1:0] be;
    } grant_t;

    typedef struct {
        logic [6:0]    rdvalid;
        logic [6:0]    complete;
        logic [DW-1:0] rdata;
    } read_t;

    function automatic grant_t exp_grant(input int m);
        grant_t g;
        g.tag   = 3'(m + 1);
        g.addr  = AW'(8'h40 + m * 5);
        g.wdata = DW'(16'hA000 + m);
        g.write = m[0];
        g.be    = BW'(m + 1);
        return g;
    endfunction

    function automatic read_t exp_read(input logic [6:0] v, input logic [6:0] c, input logic [DW-1:0] d);
        read_t r;
        r.rdvalid  = v;
        r.complete = c;
        r.rdata    = d;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- instance A: N=4, fixed priority, STARVE_LIMIT=8
    logic            rst_n_a;
    logic [3:0]      a_req, a_write, a_burst, a_hold, a_acked;
    logic [4*AW-1:0] a_addr;
    logic [4*BW-1:0] a_be;
    logic [4*DW-1:0] a_wdata;
    logic [3:0]      a_bus_ack, a_rdvalid, a_complete;
    logic [DW-1:0]   a_rdata;
    logic [2:0]      a_sreq;
    logic [AW-1:0]   a_saddr;
    logic            a_swrite, a_sburst;
    logic [BW-1:0]   a_sbe;
    logic [DW-1:0]   a_swdata;
    logic            a_sack, a_ack_en;
    logic [DW-1:0]   a_srdata;
    logic [2:0]      a_srdvalid;
    logic            a_scomplete;

    sdram_arbiter_n #(.NUM_MASTERS(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .ARB_MODE(ARB_FIXED), .STARVE_LIMIT(8)) u_dut_a (
        .clock(clk), .reset_n(rst_n_a),
        .bus_request(a_req), .bus_addr(a_addr), .bus_write(a_write), .bus_burst(a_burst),
        .bus_byte_enable(a_be), .bus_wdata(a_wdata),
        .bus_ack(a_bus_ack), .bus_rdata(a_rdata), .bus_rdvalid(a_rdvalid), .bus_complete(a_complete),
        .sdram_req(a_sreq), .sdram_addr(a_saddr), .sdram_write(a_swrite), .sdram_burst(a_sburst),
        .sdram_byte_enable(a_sbe), .sdram_wdata(a_swdata),
        .sdram_ack(a_sack), .sdram_rdata(a_srdata), .sdram_rdvalid(a_srdvalid), .sdram_complete(a_scomplete)
    );

    // ---------------- instance B: N=4, round-robin
    logic            rst_n_b;
    logic [3:0]      b_req, b_write, b_burst, b_hold, b_acked;
    logic [4*AW-1:0] b_addr;
    logic [4*BW-1:0] b_be;
    logic [4*DW-1:0] b_wdata;
    logic [3:0]      b_bus_ack, b_rdvalid, b_complete;
    logic [DW-1:0]   b_rdata;
    logic [2:0]      b_sreq;
    logic [AW-1:0]   b_saddr;
    logic            b_swrite, b_sburst;
    logic [BW-1:0]   b_sbe;
    logic [DW-1:0]   b_swdata;
    logic            b_sack, b_ack_en;
    logic [DW-1:0]   b_srdata;
    logic [2:0]      b_srdvalid;
    logic            b_scomplete;

    sdram_arbiter_n #(.NUM_MASTERS(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .ARB_MODE(ARB_RR), .STARVE_LIMIT(8)) u_dut_b (
        .clock(clk), .reset_n(rst_n_b),
        .bus_request(b_req), .bus_addr(b_addr), .bus_write(b_write), .bus_burst(b_burst),
        .bus_byte_enable(b_be), .bus_wdata(b_wdata),
        .bus_ack(b_bus_ack), .bus_rdata(b_rdata), .bus_rdvalid(b_rdvalid), .bus_complete(b_complete),
        .sdram_req(b_sreq), .sdram_addr(b_saddr), .sdram_write(b_swrite), .sdram_burst(b_sburst),
        .sdram_byte_enable(b_sbe), .sdram_wdata(b_swdata),
        .sdram_ack(b_sack), .sdram_rdata(b_srdata), .sdram_rdvalid(b_srdvalid), .sdram_complete(b_scomplete)
    );

    // ---------------- instance C: N=7, read routing only
    logic [6:0]      c_req, c_write, c_burst;
    logic [7*AW-1:0] c_addr;
    logic [7*BW-1:0] c_be;
    logic [7*DW-1:0] c_wdata;
    logic [6:0]      c_bus_ack, c_rdvalid, c_complete;
    logic [DW-1:0]   c_rdata;
    logic [2:0]      c_sreq;
    logic [AW-1:0]   c_saddr;
    logic            c_swrite, c_sburst;
    logic [BW-1:0]   c_sbe;
    logic [DW-1:0]   c_swdata;
    logic            c_sack;
    logic [DW-1:0]   c_srdata;
    logic [2:0]      c_srdvalid;
    logic            c_scomplete;

    sdram_arbiter_n #(.NUM_MASTERS(7), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut_c (
        .clock(clk), .reset_n(rst_n_a),
        .bus_request(c_req), .bus_addr(c_addr), .bus_write(c_write), .bus_burst(c_burst),
        .bus_byte_enable(c_be), .bus_wdata(c_wdata),
        .bus_ack(c_bus_ack), .bus_rdata(c_rdata), .bus_rdvalid(c_rdvalid), .bus_complete(c_complete),
        .sdram_req(c_sreq), .sdram_addr(c_saddr), .sdram_write(c_swrite), .sdram_burst(c_sburst),
        .sdram_byte_enable(c_sbe), .sdram_wdata(c_swdata),
        .sdram_ack(c_sack), .sdram_rdata(c_srdata), .sdram_rdvalid(c_srdvalid), .sdram_complete(c_scomplete)
    );

    // ---------------- scoreboards
    grant_t a_gq[$];
    grant_t b_gq[$];
    read_t  a_rq[$];
    read_t  c_rq[$];

    logic [2:0] a_prev_sreq = '0, b_prev_sreq = '0, a_cur = 3'd1, b_cur = 3'd1;
    logic       a_prev_ack = 1'b0, b_prev_ack = 1'b0;

    initial begin
        a_acked = '0;
        b_acked = '0;
    end

    always @(negedge clk) begin
        grant_t g;
        read_t  r;
        a_acked = a_bus_ack;
        b_acked = b_bus_ack;
        if (!rst_n_a) begin
            a_prev_sreq = '0;
            a_prev_ack  = 1'b0;
        end else begin
            if (a_prev_ack) begin
                check("a_dead_cycle", a_sreq, 0);
            end else if (a_sreq != 0 && a_prev_sreq == 0) begin
                if (a_gq.size() == 0) begin
                    check("a_grant_unexpected", a_sreq, 0);
                end else begin
                    g = a_gq.pop_front();
                    a_cur = g.tag;
                    check("a_grant_tag", a_sreq, g.tag);
                    check("a_grant_addr", a_saddr, g.addr);
                    check("a_grant_wdata", a_swdata, g.wdata);
                    check("a_grant_write", a_swrite, g.write);
                    check("a_grant_be", a_sbe, g.be);
                end
            end
            check("a_bus_ack", a_bus_ack, a_sack ? (4'b0001 << (a_cur - 3'd1)) : 4'b0000);
            a_prev_sreq = a_sreq;
            a_prev_ack  = a_sack;
            if (a_rdvalid != 0 || a_complete != 0) begin
                if (a_rq.size() == 0) begin
                    check("a_read_unexpected", {a_complete, a_rdvalid}, 0);
                end else begin
                    r = a_rq.pop_front();
                    check("a_rdvalid", a_rdvalid, r.rdvalid);
                    check("a_complete", a_complete, r.complete);
                    check("a_rdata", a_rdata, r.rdata);
                end
            end
            if (c_rdvalid != 0 || c_complete != 0) begin
                if (c_rq.size() == 0) begin
                    check("c_read_unexpected", {c_complete, c_rdvalid}, 0);
                end else begin
                    r = c_rq.pop_front();
                    check("c_rdvalid", c_rdvalid, r.rdvalid);
                    check("c_complete", c_complete, r.complete);
                    check("c_rdata", c_rdata, r.rdata);
                end
            end
        end
        if (!rst_n_b) begin
            b_prev_sreq = '0;
            b_prev_ack  = 1'b0;
        end else begin
            if (b_prev_ack) begin
                check("b_dead_cycle", b_sreq, 0);
            end else if (b_sreq != 0 && b_prev_sreq == 0) begin
                if (b_gq.size() == 0) begin
                    check("b_grant_unexpected", b_sreq, 0);
                end else begin
                    g = b_gq.pop_front();
                    b_cur = g.tag;
                    check("b_grant_tag", b_sreq, g.tag);
                    check("b_grant_addr", b_saddr, g.addr);
                    check("b_grant_wdata", b_swdata, g.wdata);
                end
            end
            check("b_bus_ack", b_bus_ack, b_sack ? (4'b0001 << (b_cur - 3'd1)) : 4'b0000);
            b_prev_sreq = b_sreq;
            b_prev_ack  = b_sack;
        end
    end

    // One clock: masters release acked requests (unless held), controller acks.
    task automatic step();
        @(posedge clk);
        #1;
        a_req  = a_req & ~(a_acked & ~a_hold);
        a_sack = a_ack_en && (a_sreq != 0);
        b_req  = b_req & ~(b_acked & ~b_hold);
        b_sack = b_ack_en && (b_sreq != 0);
    endtask

    task automatic wait_a_idle(input int release_at);
        int n;
        n = 0;
        while (!(a_gq.size() == 0 && a_req == 0 && a_sreq == 0) && n < 60) begin
            step();
            n++;
            if (a_gq.size() <= release_at) a_hold = '0;
        end
        check("a_idle_timeout", (n < 60), 1);
    endtask

    task automatic wait_b_idle();
        int n;
        n = 0;
        while (!(b_gq.size() == 0 && b_req == 0 && b_sreq == 0) && n < 60) begin
            step();
            n++;
        end
        check("b_idle_timeout", (n < 60), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        grant_t g;
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        a_req = '0; a_write = '0; a_burst = '0; a_hold = '0; a_sack = 1'b0; a_ack_en = 1'b1;
        b_req = '0; b_write = '0; b_burst = '0; b_hold = '0; b_sack = 1'b0; b_ack_en = 1'b1;
        a_srdata = '0; a_srdvalid = '0; a_scomplete = 1'b0;
        b_srdata = '0; b_srdvalid = '0; b_scomplete = 1'b0;
        for (int i = 0; i < 4; i++) begin
            g = exp_grant(i);
            a_addr[i*AW +: AW] = g.addr;  b_addr[i*AW +: AW] = g.addr;
            a_wdata[i*DW +: DW] = g.wdata; b_wdata[i*DW +: DW] = g.wdata;
            a_be[i*BW +: BW] = g.be;      b_be[i*BW +: BW] = g.be;
            a_write[i] = g.write;         b_write[i] = g.write;
        end
        c_req = '0; c_write = '0; c_burst = '0; c_addr = '0; c_be = '0; c_wdata = '0;
        c_sack = 1'b0; c_srdata = '0; c_srdvalid = '0; c_scomplete = 1'b0;

        repeat (3) step();
        check("a_reset_req", a_sreq, 0);
        check("a_reset_ack", a_bus_ack, 0);
        check("b_reset_req", b_sreq, 0);
        check("b_reset_ack", b_bus_ack, 0);
        check("c_reset_req", c_sreq, 0);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        step();

        // Fixed: masters 1 and 3 together -> tag 2, dead cycle, tag 4
        a_gq.push_back(exp_grant(1));
        a_gq.push_back(exp_grant(3));
        a_req = 4'b1010;
        wait_a_idle(-1);

        // Fixed starvation: master 0 continuous, master 2 wins after 8 waits
        for (int k = 0; k < 4; k++) a_gq.push_back(exp_grant(0));
        a_gq.push_back(exp_grant(2));
        a_gq.push_back(exp_grant(0));
        a_hold = 4'b0001;
        a_req  = 4'b0101;
        wait_a_idle(1);

        // Read routing while master 1 is granted and not acked
        a_ack_en = 1'b0;
        a_gq.push_back(exp_grant(1));
        a_req = 4'b0010;
        n = 0;
        while (a_sreq != 3'd2 && n < 10) begin step(); n++; end
        check("a_grant_wait_timeout", (n < 10), 1);
        a_rq.push_back(exp_read(7'b0000100, 7'b0000100, 16'hBEEF));
        a_srdvalid = 3'd3; a_scomplete = 1'b1; a_srdata = 16'hBEEF;
        step();
        a_rq.push_back(exp_read(7'b0000001, 7'b0000000, 16'h1234));
        a_srdvalid = 3'd1; a_scomplete = 1'b0; a_srdata = 16'h1234;
        step();
        a_srdvalid = 3'd5; a_scomplete = 1'b1;
        #2;
        check("a_tag_over_range_rdvalid", a_rdvalid, 0);
        check("a_tag_over_range_complete", a_complete, 0);
        step();
        a_srdvalid = 3'd0; a_scomplete = 1'b1;
        #2;
        check("a_tag_zero_rdvalid", a_rdvalid, 0);
        check("a_tag_zero_complete", a_complete, 0);
        step();
        a_scomplete = 1'b0;
        a_ack_en = 1'b1;
        wait_a_idle(-1);

        // Round-robin: all request continuously -> 1,0,2,0,3,0,4,0,1
        for (int k = 0; k < 4; k++) b_gq.push_back(exp_grant(k));
        b_gq.push_back(exp_grant(0));
        b_hold = 4'b1111;
        b_req  = 4'b1111;
        n = 0;
        while (!(b_gq.size() == 0 && b_req == 0 && b_sreq == 0) && n < 60) begin
            step();
            n++;
            if (b_gq.size() <= 1 && b_hold != 0) begin
                b_hold = '0;
                b_req  = 4'b0001;
            end
        end
        check("b_rr_timeout", (n < 60), 1);

        // Reset during GRANT: no ack, request abandoned, pointer back to 3
        b_ack_en = 1'b0;
        b_gq.push_back(exp_grant(1));
        b_req = 4'b0010;
        n = 0;
        while (b_sreq != 3'd2 && n < 10) begin step(); n++; end
        check("b_grant_wait_timeout", (n < 10), 1);
        step();
        rst_n_b = 1'b0;
        step();
        check("b_midgrant_reset_req", b_sreq, 0);
        check("b_midgrant_reset_ack", b_bus_ack, 0);
        rst_n_b  = 1'b1;
        b_ack_en = 1'b1;
        for (int k = 0; k < 4; k++) b_gq.push_back(exp_grant(k));
        b_req = 4'b1111;
        wait_b_idle();

        // N=7 read routing
        c_rq.push_back(exp_read(7'b1000000, 7'b1000000, 16'hCAFE));
        c_srdvalid = 3'd7; c_scomplete = 1'b1; c_srdata = 16'hCAFE;
        step();
        c_rq.push_back(exp_read(7'b0001000, 7'b0000000, 16'h0F0F));
        c_srdvalid = 3'd4; c_scomplete = 1'b0; c_srdata = 16'h0F0F;
        step();
        c_srdvalid = 3'd0; c_scomplete = 1'b1;
        #2;
        check("c_tag_zero_rdvalid", c_rdvalid, 0);
        check("c_tag_zero_complete", c_complete, 0);
        step();
        c_scomplete = 1'b0;
        step();

        check("a_grants_left", a_gq.size(), 0);
        check("b_grants_left", b_gq.size(), 0);
        check("a_reads_left", a_rq.size(), 0);
        check("c_reads_left", c_rq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter_n.md
SDRAM_ARBITER_N -- requirements
Module: sdram_arbiter_n

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of requesting masters (legal 2..7).
REQ-002 SHALL have parameter ADDR_WIDTH, default 26, SDRAM word-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width; byte-enable width = DATA_WIDTH/8.
REQ-004 SHALL have parameter ARB_MODE, default ARB_FIXED, selecting ARB_FIXED (lowest index wins) or ARB_RR (round-robin).
REQ-005 SHALL have parameter STARVE_LIMIT, default 64, wait cycles before a fixed-mode master is promoted.
REQ-006 Ports; ID_W = clog2(NUM_MASTERS+1); tag 0 = none, tag i+1 = master i:
- clock  input  1  system clock; one clock, all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- bus_request  input  NUM_MASTERS  per-master request, held until that master's ack.
- bus_addr  input  NUM_MASTERS*ADDR_WIDTH  per-master address, packed.
- bus_write  input  NUM_MASTERS  1 = write.
- bus_burst  input  NUM_MASTERS  1 = burst read.
- bus_byte_enable  input  NUM_MASTERS*DATA_WIDTH/8  write byte enables.
- bus_wdata  input  NUM_MASTERS*DATA_WIDTH  write data.
- bus_ack  output  NUM_MASTERS  request accepted.
- bus_rdata  output  DATA_WIDTH  read data, broadcast to all masters.
- bus_rdvalid  output  NUM_MASTERS  bus_rdata valid for that master.
- bus_complete  output  NUM_MASTERS  last read beat for that master.
- sdram_req  output  ID_W  tag of granted master, 0 = idle.
- sdram_addr/sdram_write/sdram_burst/sdram_byte_enable/sdram_wdata  output  ADDR_WIDTH/1/1/DATA_WIDTH/8/DATA_WIDTH  granted master's fields.
- sdram_ack  input  1  controller accepted current request.
- sdram_rdata  input  DATA_WIDTH  read data.
- sdram_rdvalid  input  ID_W  tag owning sdram_rdata, 0 = none.
- sdram_complete  input  1  final beat, qualified by sdram_rdvalid.

Function
REQ-007 SHALL implement states IDLE and GRANT; grant index registered.
REQ-008 IDLE with any bus_request: SHALL choose winner, load grant, enter GRANT; sdram_req = winner+1 the following cycle.
REQ-009 GRANT: sdram_* fields SHALL be combinational mux of granted master's inputs; sdram_req held until sdram_ack.
REQ-010 bus_ack[g] SHALL equal sdram_ack in GRANT (same cycle, zero latency); all other bus_ack bits 0.
REQ-011 On sdram_ack SHALL return to IDLE, sdram_req = 0 next cycle; one dead cycle before next grant.
REQ-012 Request dropped before ack SHALL be ignored; grant held until sdram_ack (protocol violation, asserted in sim).
REQ-013 ARB_FIXED: lowest-index requesting master wins, unless starved.
REQ-014 ARB_RR: search begins at index (last_grant+1) mod NUM_MASTERS; last_grant updates on ack; reset value NUM_MASTERS-1.
REQ-015 Per-master wait counter (ARB_FIXED only): increments each cycle master requests and is not granted; saturates at STARVE_LIMIT; clears on its ack or request low.
REQ-016 Any counter at STARVE_LIMIT: lowest-index starved master SHALL win over priority.
REQ-017 bus_rdvalid[i] = (sdram_rdvalid == i+1); bus_complete[i] = sdram_complete AND bus_rdvalid[i]; bus_rdata = sdram_rdata; all combinational.
REQ-018 Read return routing SHALL be independent of grant state (reads return while another master is granted).
REQ-019 Tag values above NUM_MASTERS on sdram_rdvalid SHALL assert no bus_rdvalid.

Reset
REQ-020 reset_n low at a clock edge: state IDLE, sdram_req 0, wait counters 0, last_grant NUM_MASTERS-1; bus_ack 0.
REQ-021 Reset mid-GRANT SHALL abandon request without ack; sdram_req 0 the cycle after reset sampled.

Structure
REQ-022 Package sdram_arb_pkg SHALL hold arb_mode_t (ARB_FIXED, ARB_RR), arb_state_t, ID_W helper function.
REQ-023 Winner selection SHALL be sub-module arb_picker (request vector, start index, starved vector -> winner index, valid), purely combinational.

Verification
REQ-024 N=4 fixed, masters 1 and 3 request same cycle -> sdram_req=2 one cycle later; after ack, sdram_req=0 one cycle, then 4.
REQ-025 N=4 RR, all request continuously, ack each grant immediately -> sdram_req sequence 1,0,2,0,3,0,4,0,1.
REQ-026 N=4 fixed, STARVE_LIMIT=8, master 0 requests continuously, master 2 requests -> master 2 granted within 8 wait cycles plus one grant period.
REQ-027 Master 1 granted, sdram_rdvalid=3 with sdram_complete=1 -> bus_rdvalid=0b0100, bus_complete=0b0100, bus_ack=0.
REQ-028 reset_n low during GRANT with sdram_req=2 -> sdram_req=0 next cycle, no bus_ack, RR pointer 3.
REQ-029 N=7, sdram_rdvalid=0 and tag 7 -> only bus_rdvalid[6] on tag 7; no output for tag 0.
